// File: rtl/pq_access_arbiter.sv
// Round-robin arbiter sharing one max-first priority queue among NUM_REQ requesters.
// One op in flight: grant, single-cycle queue strobe, SETTLE_CYCLES wait, tagged response.
module pq_access_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [2*NUM_REQ-1:0]          i_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_busy,
  output logic                          o_resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    o_resp_id,
  output logic [DATA_WIDTH-1:0]         o_resp_data,
  output logic                          o_resp_err,
  output logic                          o_pq_wrt,
  output logic                          o_pq_read,
  output logic [DATA_WIDTH-1:0]         o_pq_data,
  input  logic                          i_pq_full,
  input  logic                          i_pq_empty,
  input  logic [DATA_WIDTH-1:0]         i_pq_data
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [1:0] OP_ENQ = 2'b00;
  localparam logic [1:0] OP_DEQ = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

  state_t                r_state, w_state_nx;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nx;
  logic [ID_W-1:0]       r_ptr, r_id;
  logic                  r_enq, r_err;
  logic [DATA_WIDTH-1:0] r_old;

  logic [NUM_REQ-1:0]    r_gnt, w_gnt_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_resp_valid, w_resp_valid_nx;
  logic [ID_W-1:0]       r_resp_id, w_resp_id_nx;
  logic [DATA_WIDTH-1:0] r_resp_data, w_resp_data_nx;
  logic                  r_resp_err, w_resp_err_nx;
  logic                  r_pq_wrt, w_pq_wrt_nx;
  logic                  r_pq_read, w_pq_read_nx;
  logic [DATA_WIDTH-1:0] r_pq_data, w_pq_data_nx;

  logic                  w_found;
  logic [ID_W-1:0]       w_cand, w_win;
  logic [1:0]            w_win_op;
  logic [DATA_WIDTH-1:0] w_win_dat;
  logic                  w_wrt, w_rd, w_err;

  // First asserted request strictly after the last winner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_win_op  = 2'b00;
    w_win_dat = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == ID_W'(k)) begin
        w_win_op  = i_op[2*k +: 2];
        w_win_dat = i_data[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_wrt = 1'b0;
    w_rd  = 1'b0;
    w_err = 1'b0;
    case (w_win_op)
      OP_ENQ:  if (!i_pq_full) w_wrt = 1'b1; else w_err = 1'b1;
      OP_DEQ:  if (!i_pq_empty) w_rd = 1'b1; else w_err = 1'b1;
      OP_REP:  if (!i_pq_empty) begin w_wrt = 1'b1; w_rd = 1'b1; end else w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // Outputs are registered, so next-cycle output values are decided with the next state.
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_gnt_nx        = '0;
    w_resp_valid_nx = 1'b0;
    w_resp_id_nx    = '0;
    w_resp_data_nx  = '0;
    w_resp_err_nx   = 1'b0;
    w_pq_wrt_nx     = 1'b0;
    w_pq_read_nx    = 1'b0;
    w_pq_data_nx    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx      = S_ISSUE;
          w_gnt_nx[w_win] = 1'b1;
          w_pq_wrt_nx     = w_wrt;
          w_pq_read_nx    = w_rd;
          w_pq_data_nx    = w_win_dat;
        end
      end
      S_ISSUE: begin
        w_state_nx = S_SETTLE;
        w_cnt_nx   = CNT_W'(1);
      end
      S_SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYCLES)) begin
          w_state_nx      = S_RESP;
          w_cnt_nx        = '0;
          w_resp_valid_nx = 1'b1;
          w_resp_id_nx    = r_id;
          w_resp_err_nx   = r_err;
          if (!r_err) w_resp_data_nx = r_enq ? i_pq_data : r_old;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_enq        <= 1'b0;
      r_err        <= 1'b0;
      r_old        <= '0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_pq_wrt     <= 1'b0;
      r_pq_read    <= 1'b0;
      r_pq_data    <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_gnt        <= w_gnt_nx;
      r_busy       <= w_busy_nx;
      r_resp_valid <= w_resp_valid_nx;
      r_resp_id    <= w_resp_id_nx;
      r_resp_data  <= w_resp_data_nx;
      r_resp_err   <= w_resp_err_nx;
      r_pq_wrt     <= w_pq_wrt_nx;
      r_pq_read    <= w_pq_read_nx;
      r_pq_data    <= w_pq_data_nx;
      if (r_state == S_IDLE && w_found) begin
        r_ptr <= w_win;
        r_id  <= w_win;
        r_enq <= (w_win_op == OP_ENQ);
        r_err <= w_err;
      end
      // The queue takes the strobe on this edge, so this still sees the pre-op max.
      if (r_state == S_ISSUE) r_old <= i_pq_data;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_busy       = r_busy;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_data  = r_resp_data;
  assign o_resp_err   = r_resp_err;
  assign o_pq_wrt     = r_pq_wrt;
  assign o_pq_read    = r_pq_read;
  assign o_pq_data    = r_pq_data;
endmodule

// File: tb/tb_pq_access_arbiter.sv
// Bench for pq_access_arbiter: behavioural queue stub, RR/queue reference model and scoreboards.
module tb_pq_access_arbiter;
  localparam int N = 4, DW = 16, S = 5, QD = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [N-1:0]    i_req;
  logic [2*N-1:0]  i_op;
  logic [DW*N-1:0] i_data;
  logic [N-1:0]    o_gnt;
  logic            o_busy, o_resp_valid, o_resp_err, o_pq_wrt, o_pq_read;
  logic [1:0]      o_resp_id;
  logic [DW-1:0]   o_resp_data, o_pq_data, i_pq_data;
  logic            i_pq_full, i_pq_empty;

  pq_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SETTLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .i_req(i_req), .i_op(i_op), .i_data(i_data),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_resp_valid(o_resp_valid), .o_resp_id(o_resp_id),
    .o_resp_data(o_resp_data), .o_resp_err(o_resp_err), .o_pq_wrt(o_pq_wrt),
    .o_pq_read(o_pq_read), .o_pq_data(o_pq_data), .i_pq_full(i_pq_full),
    .i_pq_empty(i_pq_empty), .i_pq_data(i_pq_data));

  // Queue stub: sorted descending, updates on the strobe edge.
  logic [DW-1:0] sq [QD];
  int            sn = 0;
  initial for (int i = 0; i < QD; i++) sq[i] = '0;
  assign i_pq_full  = (sn == QD);
  assign i_pq_empty = (sn == 0);
  assign i_pq_data  = (sn == 0) ? '0 : sq[0];

  always @(posedge CLK) begin : stub
    logic [DW-1:0] t [QD];
    int n, p;
    t = sq;
    n = sn;
    if (o_pq_read && n > 0) begin
      for (int i = 0; i < QD - 1; i++) t[i] = t[i+1];
      t[QD-1] = '0;
      n--;
    end
    if (o_pq_wrt && n < QD) begin
      p = n;
      while (p > 0 && t[p-1] < o_pq_data) begin t[p] = t[p-1]; p--; end
      t[p] = o_pq_data;
      n++;
    end
    sq <= t;
    sn <= n;
  end

  typedef struct packed { logic [1:0] id; logic [DW-1:0] data; logic err; } resp_t;
  typedef struct packed { logic wrt; logic rd; logic [DW-1:0] data; } stb_t;
  resp_t rq[$];
  stb_t  sbq[$];
  int    gq[$];
  logic [DW-1:0] mq[$];
  int    mptr;
  int    errors = 0, checks = 0;
  int    cyc = 0, gnt_cyc = 0, req_cyc = 0;
  logic  prev_stb = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_gnt, o_busy, o_resp_valid, o_resp_id, o_resp_data, o_resp_err,
                 o_pq_wrt, o_pq_read, o_pq_data}, 64'd0);
  endtask

  // Reference model: one op against a sorted list, giving response and expected queue strobe.
  task automatic model_op(input int id, input logic [1:0] op, input logic [DW-1:0] d);
    resp_t r;
    int p;
    r.id = 2'(id); r.data = '0; r.err = 1'b0;
    case (op)
      2'd0: if (mq.size() == QD) r.err = 1'b1;
            else begin
              p = 0; while (p < mq.size() && mq[p] >= d) p++;
              mq.insert(p, d); r.data = mq[0]; sbq.push_back({1'b1, 1'b0, d});
            end
      2'd1: if (mq.size() == 0) r.err = 1'b1;
            else begin r.data = mq.pop_front(); sbq.push_back({1'b0, 1'b1, d}); end
      2'd2: if (mq.size() == 0) r.err = 1'b1;
            else begin
              r.data = mq.pop_front();
              p = 0; while (p < mq.size() && mq[p] >= d) p++;
              mq.insert(p, d); sbq.push_back({1'b1, 1'b1, d});
            end
      default: r.err = 1'b1;
    endcase
    rq.push_back(r);
    gq.push_back(id);
  endtask

  // Monitor: every DUT event is popped against its scoreboard.
  always @(negedge CLK) begin
    if (RST !== 1'b1) begin
      if (o_gnt != '0) begin
        if (gq.size() == 0) check("gnt_unexpected", 64'(o_gnt), 64'd0);
        else check("gnt_onehot", 64'(o_gnt), 64'(1 << gq.pop_front()));
        check("busy_in_issue", 64'(o_busy), 64'd1);
        gnt_cyc = cyc;
      end
      if (o_pq_wrt || o_pq_read) begin
        if (sbq.size() == 0) check("strobe_unexpected", {o_pq_wrt, o_pq_read, o_pq_data}, 64'd0);
        else check("strobe", {o_pq_wrt, o_pq_read, o_pq_data}, 64'(sbq.pop_front()));
        check("strobe_with_gnt", 64'(o_gnt != '0), 64'd1);
        check("strobe_single_cycle", 64'(prev_stb), 64'd0);
      end
      prev_stb = o_pq_wrt || o_pq_read;
      if (o_resp_valid) begin
        if (rq.size() == 0) check("resp_unexpected", 64'(o_resp_valid), 64'd0);
        else begin
          resp_t e;
          e = rq.pop_front();
          check("resp_id", 64'(o_resp_id), 64'(e.id));
          check("resp_data", 64'(o_resp_data), 64'(e.data));
          check("resp_err", 64'(o_resp_err), 64'(e.err));
        end
        check("resp_latency", 64'(cyc - gnt_cyc), 64'(S + 1));
      end
    end
  end

  task automatic run_batch(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                           input logic [DW*N-1:0] dat, input int rst_after);
    logic [N-1:0] pend, left;
    int c, b;
    pend = mask;
    while (pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        c = (mptr + k) % N;
        if (pend[c]) break;
      end
      model_op(c, ops[2*c +: 2], dat[DW*c +: DW]);
      pend[c] = 1'b0;
      mptr = c;
    end
    @(negedge CLK);
    i_op = ops; i_data = dat; i_req = mask; req_cyc = cyc;
    left = mask; b = 0;
    while (left != '0 && b < 200) begin
      @(negedge CLK);
      left = left & ~o_gnt;
      i_req = left;
      b++;
    end
    if (left != '0) begin check("grant_timeout", 64'(left), 64'd0); i_req = '0; end
    if (rst_after > 0) begin
      repeat (rst_after) @(negedge CLK);
      RST = 1'b1;
      void'(rq.pop_back());
      mptr = N - 1;
      @(negedge CLK);
      RST = 1'b0;
      check_all_zero("after_midop_reset");
    end
    b = 0;
    while ((rq.size() != 0 || o_busy) && b < 200) begin @(negedge CLK); b++; end
    if (b >= 200) check("drain_timeout", 64'(rq.size()), 64'd0);
  endtask

  task automatic single(input int id, input logic [1:0] op, input logic [DW-1:0] d,
                        input int rst_after = 0);
    logic [N-1:0] m; logic [2*N-1:0] o; logic [DW*N-1:0] x;
    m = '0; o = '0; x = '0;
    m[id] = 1'b1; o[2*id +: 2] = op; x[DW*id +: DW] = d;
    run_batch(m, o, x, rst_after);
  endtask

  initial begin
    logic [2*N-1:0] ops;
    logic [DW*N-1:0] dat;
    RST = 1'b1; i_req = '0; i_op = '0; i_data = '0; mptr = N - 1;
    repeat (2) @(negedge CLK);
    check_all_zero("reset_outputs");
    RST = 1'b0;

    run_batch(4'b1001, {2'd1, 2'd1, 2'd1, 2'd1}, '0, 0);      // req0 before req3
    single(1, 2'd0, 16'h0123);
    check("enq_grant_delay", 64'(gnt_cyc - req_cyc), 64'd1);
    single(0, 2'd1, 16'h0);
    single(0, 2'd0, 16'd900); single(1, 2'd0, 16'd700);
    single(2, 2'd0, 16'd50);  single(3, 2'd0, 16'd3);
    dat = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    run_batch(4'b1111, {2'd1, 2'd1, 2'd1, 2'd1}, dat, 0);     // grants 0,1,2,3
    single(0, 2'd1, 16'h0);                                    // deq on empty
    single(0, 2'd0, 16'd900); single(1, 2'd0, 16'd1);
    single(2, 2'd0, 16'd2);   single(3, 2'd0, 16'd4);
    single(2, 2'd0, 16'd7);                                    // enq on full
    single(0, 2'd3, 16'd9);                                    // illegal op
    single(3, 2'd2, 16'd5);                                    // replace top 900
    single(1, 2'd1, 16'h0, 3);                                 // reset during settle
    run_batch(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, '0, 0);      // RR restarts at req0

    for (int r = 0; r < 60; r++) begin
      for (int k = 0; k < N; k++) begin
        int sel;
        sel = $urandom_range(0, 9);
        ops[2*k +: 2] = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
        dat[DW*k +: DW] = 16'($urandom);
      end
      run_batch(4'($urandom_range(1, 15)), ops, dat, (r % 17 == 5) ? 2 : 0);
    end

    repeat (3) @(negedge CLK);
    check("scoreboards_drained", 64'(rq.size() + gq.size() + sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
